// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg
//   Shared types and constants for the round-robin memory arbiter.
//   - arbiter_state_t        : FSM state encoding (IDLE, ACCESS, RELEASE)
//   - requester_index_width  : index width for a given requester count (min 1 bit)
//   - REQUESTER_INDEX_WIDTH  : index width for the default four-requester build
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } arbiter_state_t;

  localparam int DEFAULT_NUMBER_OF_REQUESTERS = 4;

  function automatic int requester_index_width(input int number_of_requesters);
    return (number_of_requesters > 1) ? $clog2(number_of_requesters) : 1;
  endfunction

  localparam int REQUESTER_INDEX_WIDTH = requester_index_width(DEFAULT_NUMBER_OF_REQUESTERS);

endpackage

// File: rtl/memory_arbiter_round_robin_picker.sv
// round_robin_picker
//   Purely combinational round-robin search. Starting one past i_lastGranted
//   and wrapping modulo NUMBER_OF_REQUESTERS, returns the first active request.
//   Ports:
//     i_requestVector : per-master request bits
//     i_lastGranted   : index of the most recently granted master
//     o_pickOneHot    : one-hot winner (all zero when nothing requests)
//     o_pickIndex     : binary index of the winner
//     o_anyRequest    : at least one request bit is set
module round_robin_picker
  import memory_arbiter_pkg::*;
#(
  parameter int NUMBER_OF_REQUESTERS = 4,
  parameter int INDEX_WIDTH          = REQUESTER_INDEX_WIDTH
) (
  input  logic [NUMBER_OF_REQUESTERS-1:0] i_requestVector,
  input  logic [INDEX_WIDTH-1:0]          i_lastGranted,
  output logic [NUMBER_OF_REQUESTERS-1:0] o_pickOneHot,
  output logic [INDEX_WIDTH-1:0]          o_pickIndex,
  output logic                            o_anyRequest
);

  logic w_found;
  int   w_candidate;

  always_comb begin
    o_pickOneHot = '0;
    o_pickIndex  = '0;
    o_anyRequest = |i_requestVector;
    w_found      = 1'b0;
    w_candidate  = 0;
    // Offset N wraps back to lastGranted itself, so a lone requester that was
    // served last is still picked.
    for (int offset = 1; offset <= NUMBER_OF_REQUESTERS; offset++) begin
      w_candidate = (int'(i_lastGranted) + offset) % NUMBER_OF_REQUESTERS;
      if (!w_found && i_requestVector[INDEX_WIDTH'(w_candidate)]) begin
        w_found                                = 1'b1;
        o_pickOneHot[INDEX_WIDTH'(w_candidate)] = 1'b1;
        o_pickIndex                            = INDEX_WIDTH'(w_candidate);
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares one single-port RAM between NUMBER_OF_REQUESTERS masters with
//   round-robin arbitration. FSM: IDLE -> ACCESS -> RELEASE -> IDLE.
//   Ports:
//     clock, reset (async, active low)
//     requesterReadEnabled/WriteEnabled/Address/DataOut : packed master inputs
//     requesterDataIn            : registered read data, broadcast
//     requesterGrant             : one-hot grant
//     requesterFunctionComplete  : one-hot single-cycle completion pulse
//     memory*                    : RAM-side interface
//     timeoutError               : watchdog pulse (only with MEMORY_ARBITER_TIMEOUT_EN)
//     debugState                 : current FSM state
//   Optional feature macro: MEMORY_ARBITER_TIMEOUT_EN adds an ACCESS watchdog
//   that gives up after TIMEOUT_CYCLES cycles without completion.
//   Handshake: a master holds read/write high until it sees its completion
//   pulse and drops it in that same cycle; dropping earlier aborts the access.
module memory_arbiter #(
  parameter int NUMBER_OF_REQUESTERS  = 4,
  parameter int ADDRESS_WIDTH         = 32,
  parameter int DATA_WIDTH            = 32,
  parameter int REQUESTER_INDEX_WIDTH = memory_arbiter_pkg::requester_index_width(NUMBER_OF_REQUESTERS),
  parameter int TIMEOUT_CYCLES        = 64
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic [NUMBER_OF_REQUESTERS-1:0]            requesterReadEnabled,
  input  logic [NUMBER_OF_REQUESTERS-1:0]            requesterWriteEnabled,
  input  logic [NUMBER_OF_REQUESTERS*ADDRESS_WIDTH-1:0] requesterAddress,
  input  logic [NUMBER_OF_REQUESTERS*DATA_WIDTH-1:0] requesterDataOut,
  output logic [DATA_WIDTH-1:0]                      requesterDataIn,
  output logic [NUMBER_OF_REQUESTERS-1:0]            requesterGrant,
  output logic [NUMBER_OF_REQUESTERS-1:0]            requesterFunctionComplete,
  output logic [ADDRESS_WIDTH-1:0]                   memoryAddress,
  output logic [DATA_WIDTH-1:0]                      memoryDataOut,
  input  logic [DATA_WIDTH-1:0]                      memoryDataIn,
  output logic                                       memoryReadEnabled,
  output logic                                       memoryWriteEnabled,
  input  logic                                       memoryFunctionComplete,
`ifdef MEMORY_ARBITER_TIMEOUT_EN
  output logic                                       timeoutError,
`endif
  output memory_arbiter_pkg::arbiter_state_t         debugState
);
  import memory_arbiter_pkg::*;

  localparam int N  = NUMBER_OF_REQUESTERS;
  localparam int IW = REQUESTER_INDEX_WIDTH;

  arbiter_state_t          r_state, w_nextState;
  logic [N-1:0]            r_grant, w_nextGrant;
  logic [IW-1:0]           r_grantIndex, w_nextGrantIndex;
  logic [IW-1:0]           r_lastGranted, w_nextLastGranted;
  logic [N-1:0]            r_complete, w_nextComplete;
  logic [DATA_WIDTH-1:0]   r_dataIn, w_nextDataIn;

  logic [N-1:0]            w_request;
  logic [N-1:0]            w_pickOneHot;
  logic [IW-1:0]           w_pickIndex;
  logic                    w_anyRequest;
  logic                    w_grantedRead, w_grantedWrite, w_grantedRequest;
  logic [ADDRESS_WIDTH-1:0] w_addrArray [N];
  logic [DATA_WIDTH-1:0]    w_dataArray [N];

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  localparam int TIMER_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TIMER_WIDTH-1:0] r_timer, w_nextTimer;
  logic                   r_timeout, w_nextTimeout;
`endif

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign w_addrArray[i] = requesterAddress[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign w_dataArray[i] = requesterDataOut[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_request        = requesterReadEnabled | requesterWriteEnabled;
  assign w_grantedRead    = requesterReadEnabled[r_grantIndex];
  assign w_grantedWrite   = requesterWriteEnabled[r_grantIndex];
  assign w_grantedRequest = w_grantedRead | w_grantedWrite;

  round_robin_picker #(
    .NUMBER_OF_REQUESTERS (N),
    .INDEX_WIDTH          (IW)
  ) u_picker (
    .i_requestVector (w_request),
    .i_lastGranted   (r_lastGranted),
    .o_pickOneHot    (w_pickOneHot),
    .o_pickIndex     (w_pickIndex),
    .o_anyRequest    (w_anyRequest)
  );

  always_comb begin
    w_nextState       = r_state;
    w_nextGrant       = r_grant;
    w_nextGrantIndex  = r_grantIndex;
    w_nextLastGranted = r_lastGranted;
    w_nextComplete    = '0;
    w_nextDataIn      = r_dataIn;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
    w_nextTimer       = r_timer;
    w_nextTimeout     = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_anyRequest) begin
          w_nextState       = ACCESS;
          w_nextGrant       = w_pickOneHot;
          w_nextGrantIndex  = w_pickIndex;
          w_nextLastGranted = w_pickIndex;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
          w_nextTimer       = '0;
`endif
        end
      end
      ACCESS: begin
        if (memoryFunctionComplete && w_grantedRequest) begin
          w_nextState    = RELEASE;
          w_nextGrant    = '0;
          w_nextComplete = r_grant;
          // A read+write request ran as a write, so there is nothing to capture.
          if (w_grantedRead && !w_grantedWrite) begin
            w_nextDataIn = memoryDataIn;
          end
        end else if (!w_grantedRequest) begin
          w_nextState = RELEASE;
          w_nextGrant = '0;
        end
`ifdef MEMORY_ARBITER_TIMEOUT_EN
        else if (r_timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          w_nextState   = RELEASE;
          w_nextGrant   = '0;
          w_nextTimeout = 1'b1;
        end else begin
          w_nextTimer = r_timer + 1'b1;
        end
`endif
      end
      // One dead cycle with enables low lets the RAM reset its delay counter.
      RELEASE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_grantIndex  <= '0;
      r_lastGranted <= IW'(N - 1);
      r_complete    <= '0;
      r_dataIn      <= '0;
    end else begin
      r_state       <= w_nextState;
      r_grant       <= w_nextGrant;
      r_grantIndex  <= w_nextGrantIndex;
      r_lastGranted <= w_nextLastGranted;
      r_complete    <= w_nextComplete;
      r_dataIn      <= w_nextDataIn;
    end
  end

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_timer   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timer   <= w_nextTimer;
      r_timeout <= w_nextTimeout;
    end
  end
  assign timeoutError = r_timeout;
`endif

  // Write wins when a master raises both enables.
  always_comb begin
    memoryReadEnabled  = 1'b0;
    memoryWriteEnabled = 1'b0;
    if (r_state == ACCESS) begin
      memoryWriteEnabled = w_grantedWrite;
      memoryReadEnabled  = w_grantedRead & ~w_grantedWrite;
    end
  end

  assign memoryAddress             = w_addrArray[r_grantIndex];
  assign memoryDataOut             = w_dataArray[r_grantIndex];
  assign requesterDataIn           = r_dataIn;
  assign requesterGrant            = r_grant;
  assign requesterFunctionComplete = r_complete;
  assign debugState                = r_state;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
//   Directed bench for memory_arbiter (4 masters, 32-bit address/data) with a
//   behavioural RAM whose completion delay is set by ram_delay.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req_rd = '0;
  logic [3:0]   req_wr = '0;
  logic [127:0] req_addr = '0;
  logic [127:0] req_dout = '0;
  logic [31:0]  data_in;
  logic [3:0]   grant;
  logic [3:0]   complete;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_dout;
  logic [31:0]  mem_din;
  logic         mem_re;
  logic         mem_we;
  logic         mem_fc;
  arbiter_state_t debug_state;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
  logic         timeout_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  memory_arbiter #(
    .NUMBER_OF_REQUESTERS (4),
    .ADDRESS_WIDTH        (32),
    .DATA_WIDTH           (32),
    .TIMEOUT_CYCLES       (8)
  ) dut (
    .clock                     (clock),
    .reset                     (reset),
    .requesterReadEnabled      (req_rd),
    .requesterWriteEnabled     (req_wr),
    .requesterAddress          (req_addr),
    .requesterDataOut          (req_dout),
    .requesterDataIn           (data_in),
    .requesterGrant            (grant),
    .requesterFunctionComplete (complete),
    .memoryAddress             (mem_addr),
    .memoryDataOut             (mem_dout),
    .memoryDataIn              (mem_din),
    .memoryReadEnabled         (mem_re),
    .memoryWriteEnabled        (mem_we),
    .memoryFunctionComplete    (mem_fc),
`ifdef MEMORY_ARBITER_TIMEOUT_EN
    .timeoutError              (timeout_err),
`endif
    .debugState                (debug_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural RAM ----------------
  logic [31:0] ram [0:255];
  int          ram_delay = 4;
  int          ram_cnt;
  logic        ram_stall = 1'b0;
  logic        load_en = 1'b0;
  logic [7:0]  load_a = '0;
  logic [31:0] load_d = '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ram_cnt <= 0;
      mem_fc  <= 1'b0;
    end else begin
      if (load_en) ram[load_a] <= load_d;
      if (!(mem_re || mem_we)) begin
        ram_cnt <= 0;
        mem_fc  <= 1'b0;
      end else if (!mem_fc && !ram_stall) begin
        if (ram_cnt == ram_delay - 1) begin
          mem_fc <= 1'b1;
          if (mem_we) ram[mem_addr[7:0]] <= mem_dout;
        end else begin
          ram_cnt <= ram_cnt + 1;
        end
      end
    end
  end

  assign mem_din = ram[mem_addr[7:0]];

  // ---------------- driver tasks ----------------
  task automatic load_ram(input logic [7:0] a, input logic [31:0] d);
    @(negedge clock);
    load_en = 1'b1; load_a = a; load_d = d;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  // Drives one transaction for master m and reports the negedge index
  // (counted from the request) of grant and completion, plus enable cycles.
  task automatic run_txn(input int m, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         output int grant_at, output int done_at,
                         output int re_cycles, output int we_cycles);
    grant_at = -1; done_at = -1; re_cycles = 0; we_cycles = 0;
    @(negedge clock);
    req_addr[m*32 +: 32] = a;
    req_dout[m*32 +: 32] = d;
    req_rd[m] = rd;
    req_wr[m] = wr;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (grant_at < 0 && grant[m]) grant_at = k;
      if (mem_re) re_cycles++;
      if (mem_we) we_cycles++;
      if (complete[m]) begin
        done_at = k;
        break;
      end
    end
    req_rd[m] = 1'b0;
    req_wr[m] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++; if (grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    n_checks++; if (complete !== 4'b0) begin n_fail++; $display("FAIL reset_complete: got %b expected 0000", complete); end
    n_checks++; if (data_in !== 32'h0) begin n_fail++; $display("FAIL reset_data_in: got %h expected 0", data_in); end
    n_checks++; if ({mem_re, mem_we} !== 2'b00) begin n_fail++; $display("FAIL reset_enables: got %b expected 00", {mem_re, mem_we}); end
    n_checks++; if (debug_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", debug_state, IDLE); end
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    int g, dn, rc, wc;
    ram_delay = 4;
    load_ram(8'h10, 32'h0000_CAFE);
    run_txn(2, 1'b1, 1'b0, 32'h10, 32'h0, g, dn, rc, wc);
    n_checks++; if (g !== 1) begin n_fail++; $display("FAIL read_grant_latency: got %0d expected 1", g); end
    n_checks++; if (dn !== 6) begin n_fail++; $display("FAIL read_done_latency: got %0d expected 6", dn); end
    n_checks++; if (data_in !== 32'h0000_CAFE) begin n_fail++; $display("FAIL read_data: got %h expected 0000cafe", data_in); end
    n_checks++; if (rc !== 5) begin n_fail++; $display("FAIL read_re_cycles: got %0d expected 5", rc); end
    n_checks++; if (wc !== 0) begin n_fail++; $display("FAIL read_we_cycles: got %0d expected 0", wc); end
    @(negedge clock);
    n_checks++; if (complete !== 4'b0) begin n_fail++; $display("FAIL read_pulse_width: got %b expected 0000", complete); end
    n_checks++; if (debug_state !== IDLE) begin n_fail++; $display("FAIL read_back_to_idle: got %0d expected %0d", debug_state, IDLE); end
  endtask

  task automatic test_write_read();
    int g, dn, rc, wc;
    ram_delay = 4;
    // Both enables set: must execute as a write and leave the read data register alone.
    run_txn(0, 1'b1, 1'b1, 32'h3, 32'h1234, g, dn, rc, wc);
    n_checks++; if (dn !== 6) begin n_fail++; $display("FAIL write_done_latency: got %0d expected 6", dn); end
    n_checks++; if (wc !== 5) begin n_fail++; $display("FAIL write_we_cycles: got %0d expected 5", wc); end
    n_checks++; if (rc !== 0) begin n_fail++; $display("FAIL write_re_cycles: got %0d expected 0", rc); end
    n_checks++; if (data_in !== 32'h0000_CAFE) begin n_fail++; $display("FAIL write_data_held: got %h expected 0000cafe", data_in); end
    run_txn(0, 1'b1, 1'b0, 32'h3, 32'h0, g, dn, rc, wc);
    n_checks++; if (data_in !== 32'h0000_1234) begin n_fail++; $display("FAIL readback_data: got %h expected 00001234", data_in); end
    n_checks++; if (wc !== 0) begin n_fail++; $display("FAIL readback_we_cycles: got %0d expected 0", wc); end
    n_checks++; if (dn !== 6) begin n_fail++; $display("FAIL readback_done_latency: got %0d expected 6", dn); end
  endtask

  task automatic test_round_robin();
    int order[5];
    int exp_order[5];
    int done_cnt[4];
    int idx;
    logic got;
    exp_order = '{0, 1, 2, 3, 0};
    done_cnt = '{0, 0, 0, 0};
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    ram_delay = 2;
    for (int i = 0; i < 4; i++) begin
      load_ram(8'(8'h20 + i), 32'hA0 + 32'(i));
      req_addr[i*32 +: 32] = 32'h20 + 32'(i);
    end
    @(negedge clock);
    req_rd = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      idx = -1;
      for (int k = 0; k < 50 && idx < 0; k++) begin
        @(negedge clock);
        for (int b = 0; b < 4; b++) if (grant[b]) idx = b;
      end
      order[t] = idx;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
        @(negedge clock);
        if (|complete) begin
          got = 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (complete[b]) begin
              if (t < 4) done_cnt[b]++;
              req_rd[b] = 1'b0;
            end
          end
        end
      end
      @(negedge clock);
      if (t < 4) req_rd = 4'b1111;
      else       req_rd = 4'b0000;
    end
    for (int t = 0; t < 5; t++) begin
      n_checks++; if (order[t] !== exp_order[t]) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", t, order[t], exp_order[t]); end
    end
    for (int b = 0; b < 4; b++) begin
      n_checks++; if (done_cnt[b] !== 1) begin n_fail++; $display("FAIL rr_completions[%0d]: got %0d expected 1", b, done_cnt[b]); end
    end
    n_checks++; if (data_in !== 32'hA0) begin n_fail++; $display("FAIL rr_last_data: got %h expected 000000a0", data_in); end
  endtask

  task automatic test_abort();
    logic got;
    ram_delay = 10;
    req_addr[1*32 +: 32] = 32'h21;
    req_addr[2*32 +: 32] = 32'h22;
    @(negedge clock);
    req_rd[1] = 1'b1;
    req_rd[2] = 1'b1;
    @(negedge clock);
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL abort_grant1: got %b expected 0010", grant); end
    @(negedge clock);
    req_rd[1] = 1'b0;
    @(negedge clock);
    n_checks++; if (debug_state !== RELEASE) begin n_fail++; $display("FAIL abort_release_state: got %0d expected %0d", debug_state, RELEASE); end
    n_checks++; if ({grant, complete, mem_re} !== 9'b0) begin n_fail++; $display("FAIL abort_release_outputs: got %b expected 0", {grant, complete, mem_re}); end
    @(negedge clock);
    n_checks++; if (debug_state !== IDLE) begin n_fail++; $display("FAIL abort_idle_state: got %0d expected %0d", debug_state, IDLE); end
    n_checks++; if (complete !== 4'b0) begin n_fail++; $display("FAIL abort_no_pulse: got %b expected 0000", complete); end
    @(negedge clock);
    n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL abort_next_grant: got %b expected 0100", grant); end
    n_checks++; if (data_in !== 32'hA0) begin n_fail++; $display("FAIL abort_data_held: got %h expected 000000a0", data_in); end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clock);
      if (complete[2]) got = 1'b1;
    end
    req_rd[2] = 1'b0;
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL abort_follow_on_done: got %b expected 1", got); end
    n_checks++; if (data_in !== 32'hA2) begin n_fail++; $display("FAIL abort_follow_on_data: got %h expected 000000a2", data_in); end
  endtask

  task automatic test_reset_mid_access();
    ram_delay = 10;
    req_addr[3*32 +: 32] = 32'h23;
    @(negedge clock);
    req_rd[3] = 1'b1;
    @(negedge clock);
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL rst_mid_grant3: got %b expected 1000", grant); end
    n_checks++; if (mem_re !== 1'b1) begin n_fail++; $display("FAIL rst_mid_re_before: got %b expected 1", mem_re); end
    @(negedge clock);
    req_rd[0] = 1'b1;
    req_rd[1] = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (grant !== 4'b0) begin n_fail++; $display("FAIL rst_mid_grant: got %b expected 0000", grant); end
    n_checks++; if ({mem_re, mem_we} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_enables: got %b expected 00", {mem_re, mem_we}); end
    n_checks++; if (complete !== 4'b0) begin n_fail++; $display("FAIL rst_mid_complete: got %b expected 0000", complete); end
    n_checks++; if (debug_state !== IDLE) begin n_fail++; $display("FAIL rst_mid_state: got %0d expected %0d", debug_state, IDLE); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_first_grant: got %b expected 0001", grant); end
    req_rd = 4'b0000;
    repeat (4) @(negedge clock);
    n_checks++; if (debug_state !== IDLE) begin n_fail++; $display("FAIL rst_mid_settle: got %0d expected %0d", debug_state, IDLE); end
  endtask

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    int seen;
    logic saw_done;
    seen = -1;
    saw_done = 1'b0;
    ram_stall = 1'b1;
    req_addr[31:0] = 32'h40;
    @(negedge clock);
    req_rd[0] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      if (|complete) saw_done = 1'b1;
      if (timeout_err) begin
        seen = k;
        break;
      end
    end
    req_rd[0] = 1'b0;
    n_checks++; if (seen !== 9) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 9", seen); end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL timeout_no_pulse: got %b expected 0", saw_done); end
    @(negedge clock);
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse_width: got %b expected 0", timeout_err); end
    n_checks++; if (debug_state !== IDLE) begin n_fail++; $display("FAIL timeout_idle: got %0d expected %0d", debug_state, IDLE); end
    ram_stall = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_round_robin();
    test_abort();
    test_reset_mid_access();
`ifdef MEMORY_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
